// File: rtl/uart_esc_tx.sv
// rtl/uart_esc_tx.sv - 8N1 UART transmitter with escape doubling, pause deferral and TX pin mux
// Accepted bytes go through START/DATA/STOP; an escape byte is sent twice back to back.
module uart_esc_tx #(
  parameter int         CLK_RATE   = 100_000_000,
  parameter int         BAUD_RATE  = 115200,
  parameter logic [7:0] ESC_SYMBOL = 8'hB1
) (
  input  logic       CLK_I,
  input  logic       RST_NI,
  input  logic       TX_START_I,
  input  logic [7:0] DATA_I,
  input  logic       ESC_EN_I,
  input  logic       SEND_PAUSE_I,
  input  logic       CHANNEL_I,
  input  logic       TX1_I,
  output logic       TX0_O,
  output logic       TX_BUSY_O,
  output logic       TX_DONE_O
);

  localparam int BIT_CYCLES = CLK_RATE / BAUD_RATE;
  localparam int CNT_W      = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             dbl_q, dbl_d;
  logic             done_q, done_d;
  logic             sel_q, sel_d;
  logic             bit_end;
  logic             ser_bit;

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    dbl_d   = dbl_q;
    done_d  = 1'b0;
    sel_d   = sel_q;

    case (state_q)
      S_IDLE: begin
        if (TX_START_I && !sel_q) begin
          data_d  = DATA_I;
          dbl_d   = ESC_EN_I && (DATA_I == ESC_SYMBOL);
          baud_d  = '0;
          bit_d   = '0;
          state_d = SEND_PAUSE_I ? S_WAIT : S_START;
        end
      end
      S_WAIT: begin
        if (!SEND_PAUSE_I) begin
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        // The doubled copy follows immediately; pause is deliberately not consulted here.
        if (bit_end) begin
          if (dbl_q) begin
            dbl_d   = 1'b0;
            state_d = S_START;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loading on the transition into IDLE lets a mid-frame switch land in the first idle cycle.
    if (state_d == S_IDLE) sel_d = CHANNEL_I;
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      dbl_q   <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      dbl_q   <= dbl_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    case (state_q)
      S_START: ser_bit = 1'b0;
      S_DATA:  ser_bit = data_q[bit_q];
      default: ser_bit = 1'b1;
    endcase
  end

  assign TX0_O     = sel_q ? TX1_I : ser_bit;
  assign TX_BUSY_O = (state_q != S_IDLE);
  assign TX_DONE_O = done_q;

endmodule

// File: tb/tb_uart_esc_tx.sv
// tb/tb_uart_esc_tx.sv - scoreboard bench for uart_esc_tx with 10 cycles per bit
module tb_uart_esc_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       esc = 1'b0;
  logic       pause = 1'b0;
  logic       chan = 1'b0;
  logic       tx1 = 1'b1;
  logic       tx0, busy, done;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic       mon_en = 1'b0;

  uart_esc_tx #(
    .CLK_RATE  (1_000_000),
    .BAUD_RATE (100_000),
    .ESC_SYMBOL(8'hB1)
  ) dut (
    .CLK_I       (clk),
    .RST_NI      (rst_n),
    .TX_START_I  (start),
    .DATA_I      (data),
    .ESC_EN_I    (esc),
    .SEND_PAUSE_I(pause),
    .CHANNEL_I   (chan),
    .TX1_I       (tx1),
    .TX0_O       (tx0),
    .TX_BUSY_O   (busy),
    .TX_DONE_O   (done)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame decoder: samples mid-bit, pops the scoreboard on each complete frame.
  initial begin
    logic [7:0] got;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx0 === 1'b0) begin
        aborted = 1'b0;
        got = 8'h00;
        for (int t = 1; t < 100; t++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (t == 5) chk_eq("start_bit", tx0, 0);
          else if (t >= 15 && t <= 85 && ((t - 15) % 10) == 0) got[(t - 15) / 10] = tx0;
          else if (t == 95) chk_eq("stop_bit", tx0, 1);
        end
        if (!aborted) begin
          chk_eq("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) chk_eq("frame_byte", got, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_req(input logic [7:0] d, input logic e);
    @(negedge clk);
    start = 1'b1;
    data  = d;
    esc   = e;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the first busy negedge; counts busy cycles up to the done cycle.
  task automatic measure(input string tag, input int exp_busy);
    int n = 0;
    int done_in_busy = 0;
    while (busy === 1'b1 && n < 1000) begin
      if (done === 1'b1) done_in_busy++;
      n++;
      @(negedge clk);
    end
    chk_eq({tag, "_busy_len"}, n, exp_busy);
    chk_eq({tag, "_done_while_busy"}, done_in_busy, 0);
    chk_eq({tag, "_done"}, done, 1);
    @(negedge clk);
    chk_eq({tag, "_done_one_cycle"}, done, 0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk_eq({tag, "_done_seen"}, done, 1);
    chk_eq({tag, "_idle_at_done"}, busy, 0);
  endtask

  initial begin
    int cnt;
    int ok;

    repeat (3) @(negedge clk);
    chk_eq("rst_tx0", tx0, 1);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Single byte
    exp_q.push_back(8'h55);
    start_req(8'h55, 1'b1);
    chk_eq("single_tx0_low", tx0, 0);
    chk_eq("single_busy", busy, 1);
    measure("single", 100);

    // Escape doubling, then the same byte without escape enable
    exp_q.push_back(8'hB1);
    exp_q.push_back(8'hB1);
    start_req(8'hB1, 1'b1);
    measure("dbl", 200);
    exp_q.push_back(8'hB1);
    start_req(8'hB1, 1'b0);
    measure("nodbl", 100);

    // Pause at accept, sampled high on 37 edges
    exp_q.push_back(8'hC3);
    @(negedge clk);
    pause = 1'b1;
    start = 1'b1;
    data  = 8'hC3;
    esc   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    repeat (36) begin
      if (tx0 === 1'b1 && busy === 1'b1) ok++;
      @(negedge clk);
    end
    chk_eq("pause_hold", ok, 36);
    pause = 1'b0;
    cnt = 37;
    while (tx0 === 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk_eq("pause_start_delay", cnt, 38);
    measure("pause", 100);

    // Pause raised mid-frame, and during the first stop bit of a doubled pair
    exp_q.push_back(8'h96);
    start_req(8'h96, 1'b1);
    fork
      begin
        repeat (40) @(negedge clk);
        pause = 1'b1;
      end
    join_none
    measure("pause_mid", 100);
    pause = 1'b0;
    exp_q.push_back(8'hB1);
    exp_q.push_back(8'hB1);
    start_req(8'hB1, 1'b1);
    fork
      begin
        repeat (95) @(negedge clk);
        pause = 1'b1;
      end
    join_none
    measure("pause_dbl", 200);
    pause = 1'b0;

    // Ignored mid-frame request, then a start in the done cycle
    exp_q.push_back(8'h0F);
    start_req(8'h0F, 1'b0);
    repeat (30) @(negedge clk);
    start = 1'b1;
    data  = 8'hAA;
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_first");
    exp_q.push_back(8'hF0);
    start = 1'b1;
    data  = 8'hF0;
    @(negedge clk);
    start = 1'b0;
    chk_eq("b2b_start_next", tx0, 0);
    measure("b2b", 100);

    // Pass-through while idle
    mon_en = 1'b0;
    @(negedge clk);
    chan = 1'b1;
    @(negedge clk);
    ok = 0;
    for (int i = 0; i < 6; i++) begin
      logic b;
      b = i[0];
      tx1 = b;
      #1;
      if (tx0 === b) ok++;
      @(negedge clk);
    end
    chk_eq("pass_follow", ok, 6);
    start = 1'b1;
    data  = 8'h55;
    @(negedge clk);
    start = 1'b0;
    chk_eq("pass_start_ignored", busy, 0);
    chan = 1'b0;
    tx1  = 1'b1;
    repeat (2) @(negedge clk);
    chk_eq("pass_off_idle", tx0, 1);
    mon_en = 1'b1;

    // Channel raised mid-frame switches in the first idle cycle
    exp_q.push_back(8'h5A);
    start_req(8'h5A, 1'b0);
    repeat (30) @(negedge clk);
    chan   = 1'b1;
    tx1    = 1'b0;
    mon_en = 1'b0;
    wait_done("chan_mid");
    chk_eq("chan_switch_at_done", tx0, 0);
    chan = 1'b0;
    tx1  = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // Asynchronous reset during data bit 4
    start_req(8'h81, 1'b0);
    repeat (53) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_tx0", tx0, 1);
    chk_eq("arst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("arst_done", done, 0);
    exp_q.push_back(8'h3C);
    start_req(8'h3C, 1'b0);
    measure("after_rst", 100);

    repeat (150) @(negedge clk);
    chk_eq("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
